// File: rtl/axis_width_downsizer_if.sv
// rtl/axis_width_downsizer_if.sv - AXI-Stream beat bundle (tdata/tvalid/tready/tlast)
interface axis_width_downsizer_if #(
    parameter int BYTES = 1
);
    logic [BYTES*8-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_width_downsizer.sv
// rtl/axis_width_downsizer.sv - splits each wide AXIS beat into RATIO narrow beats
module axis_width_downsizer #(
    parameter int AXIS_I_BYTES = 4,
    parameter int AXIS_O_BYTES = 1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic                   clk,
    input  logic                   sresetn,
    axis_width_downsizer_if.slave  axis_i,
    axis_width_downsizer_if.master axis_o
);
    localparam int RATIO = AXIS_I_BYTES / AXIS_O_BYTES;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int W     = AXIS_O_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((AXIS_I_BYTES % AXIS_O_BYTES) != 0 || RATIO < 1) begin : g_bad_ratio
        $error("AXIS_I_BYTES must be a positive integer multiple of AXIS_O_BYTES");
    end

    logic [AXIS_I_BYTES*8-1:0] held_data;
    logic                      held_last;
    logic                      held_valid;
    logic [IDX_W-1:0]          idx;

    logic                      last_chunk;
    logic                      in_ready;
    logic                      in_fire;
    logic                      out_fire;
    logic [IDX_W-1:0]          sel;
    logic [W-1:0]              chunks [RATIO];

    for (genvar k = 0; k < RATIO; k++) begin : g_chunk
        assign chunks[k] = held_data[k*W +: W];
    end

    // Ready depends only on registered state and downstream ready, never on input valid.
    always_comb begin
        last_chunk = (idx == LAST_IDX);
        in_ready   = !held_valid || (axis_o.tready && last_chunk);
        in_fire    = axis_i.tvalid && in_ready;
        out_fire   = held_valid && axis_o.tready;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            held_valid <= 1'b0;
            held_last  <= 1'b0;
            idx        <= '0;
        end else if (in_fire) begin
            held_data  <= axis_i.tdata;
            held_last  <= axis_i.tlast;
            held_valid <= 1'b1;
            idx        <= '0;
        end else if (out_fire) begin
            if (last_chunk) begin
                held_valid <= 1'b0;
                idx        <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        sel           = MSB_FIRST ? (LAST_IDX - idx) : idx;
        axis_i.tready = in_ready;
        axis_o.tvalid = held_valid;
        axis_o.tdata  = chunks[sel];
        axis_o.tlast  = held_valid && held_last && last_chunk;
    end
endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb/tb_axis_width_downsizer.sv - self-checking bench for axis_width_downsizer (LSB- and MSB-first)
module tb_axis_width_downsizer;
    logic clk = 1'b0;
    logic sresetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axis_width_downsizer_if #(.BYTES(4)) in0 ();
    axis_width_downsizer_if #(.BYTES(1)) out0 ();
    axis_width_downsizer_if #(.BYTES(4)) in1 ();
    axis_width_downsizer_if #(.BYTES(1)) out1 ();

    axis_width_downsizer #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(1'b0)) dut_lsb (
        .clk     (clk),
        .sresetn (sresetn),
        .axis_i  (in0.slave),
        .axis_o  (out0.master)
    );

    axis_width_downsizer #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(1'b1)) dut_msb (
        .clk     (clk),
        .sresetn (sresetn),
        .axis_i  (in1.slave),
        .axis_o  (out1.master)
    );

    logic       o0_valid, o0_last, o1_valid, o1_last, rdy0, rdy1;
    logic [7:0] o0_data, o1_data;

    // Applies one cycle of stimulus at the falling edge and samples settled outputs just after.
    task automatic drive(input logic rn, input logic iv, input logic [31:0] id,
                         input logic il, input logic ordy);
        @(negedge clk);
        sresetn     = rn;
        in0.tvalid  = iv;  in1.tvalid = iv;
        in0.tdata   = id;  in1.tdata  = id;
        in0.tlast   = il;  in1.tlast  = il;
        out0.tready = ordy; out1.tready = ordy;
        #1;
        o0_valid = out0.tvalid; o0_data = out0.tdata; o0_last = out0.tlast; rdy0 = in0.tready;
        o1_valid = out1.tvalid; o1_data = out1.tdata; o1_last = out1.tlast; rdy1 = in1.tready;
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1);
            if (i > 0) begin
                checks++;
                if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin
                    errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", o0_valid, o1_valid);
                end
                checks++;
                if (o0_last !== 1'b0 || o1_last !== 1'b0) begin
                    errors++; $display("FAIL reset_last: got %b/%b expected 0/0", o0_last, o1_last);
                end
            end
        end
        drive(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
        checks++;
        if (o0_valid !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL reset_release: got valid=%b ready=%b expected valid=0 ready=1", o0_valid, rdy0);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o0_valid !== 1'b1 || o0_data !== 8'h78 || o1_valid !== 1'b1 || o1_data !== 8'h12) begin
            errors++; $display("FAIL reset_first_out: got %b/%h %b/%h expected 1/78 1/12", o0_valid, o0_data, o1_valid, o1_data);
        end
        flush();
    endtask

    task automatic test_single_beat();
        logic [31:0] beat = 32'hDDCCBBAA;
        drive(1'b1, 1'b1, beat, 1'b1, 1'b1);
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            errors++; $display("FAIL single_accept: got %b/%b expected 1/1", rdy0, rdy1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (o0_valid !== 1'b1 || o0_data !== beat[8*k +: 8] || o0_last !== (k == 3)) begin
                errors++; $display("FAIL single_lsb chunk %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                   k, o0_valid, o0_data, o0_last, beat[8*k +: 8], (k == 3));
            end
            checks++;
            if (o1_valid !== 1'b1 || o1_data !== beat[8*(3-k) +: 8] || o1_last !== (k == 3)) begin
                errors++; $display("FAIL single_msb chunk %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                   k, o1_valid, o1_data, o1_last, beat[8*(3-k) +: 8], (k == 3));
            end
            checks++;
            if (rdy0 !== (k == 3) || rdy1 !== (k == 3)) begin
                errors++; $display("FAIL single_ready chunk %0d: got %b/%b expected %b", k, rdy0, rdy1, (k == 3));
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got %b/%b expected 0/0", o0_valid, o1_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] beats [2];
        logic        lasts [2];
        int          bi = 0;
        int          n;
        beats[0] = 32'h03020100; lasts[0] = 1'b0;
        beats[1] = 32'h07060504; lasts[1] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, bi < 2, beats[bi < 2 ? bi : 1], lasts[bi < 2 ? bi : 1], 1'b1);
            if (c >= 1) begin
                n = c - 1;
                checks++;
                if (o0_valid !== 1'b1 || o0_data !== 8'(n) || o0_last !== (n == 7)) begin
                    errors++; $display("FAIL b2b_lsb out %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                       n, o0_valid, o0_data, o0_last, 8'(n), (n == 7));
                end
                checks++;
                if (o1_valid !== 1'b1 || o1_data !== 8'((n / 4) * 4 + 3 - (n % 4)) || o1_last !== (n == 7)) begin
                    errors++; $display("FAIL b2b_msb out %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                       n, o1_valid, o1_data, o1_last, 8'((n / 4) * 4 + 3 - (n % 4)), (n == 7));
                end
            end
            if (bi < 2 && rdy0) bi++;
        end
        checks++;
        if (bi != 2) begin
            errors++; $display("FAIL b2b_accepted: got %0d beats expected 2", bi);
        end
        flush();
    endtask

    task automatic test_random();
        logic [8:0]  q0 [$];
        logic [8:0]  q1 [$];
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        logic        pend = 1'b0;
        logic        ordy;
        logic        exp_rdy;
        int          pkt_left = 0;
        int          accepted = 0;
        int          cycles = 0;
        while ((accepted < 1000 || q0.size() != 0 || q1.size() != 0) && cycles < 20000) begin
            if (!pend && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                pd = $urandom;
                if (pkt_left == 0) pkt_left = $urandom_range(1, 8);
                pl = (pkt_left == 1);
                pkt_left--;
                pend = 1'b1;
            end
            ordy = 1'($urandom_range(0, 1));
            drive(1'b1, pend, pd, pl, ordy);
            exp_rdy = (q0.size() == 0) || (ordy && q0.size() == 1);
            checks++;
            if (rdy0 !== exp_rdy || rdy1 !== exp_rdy) begin
                errors++; $display("FAIL rand_ready cyc %0d: got %b/%b expected %b", cycles, rdy0, rdy1, exp_rdy);
            end
            checks++;
            if (o0_valid !== (q0.size() != 0) || o1_valid !== (q1.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d: got %b/%b expected %b", cycles, o0_valid, o1_valid, q0.size() != 0);
            end
            if (q0.size() != 0) begin
                checks++;
                if ({o0_last, o0_data} !== q0[0]) begin
                    errors++; $display("FAIL rand_lsb cyc %0d: got l=%b d=%h expected l=%b d=%h",
                                       cycles, o0_last, o0_data, q0[0][8], q0[0][7:0]);
                end
            end
            if (q1.size() != 0) begin
                checks++;
                if ({o1_last, o1_data} !== q1[0]) begin
                    errors++; $display("FAIL rand_msb cyc %0d: got l=%b d=%h expected l=%b d=%h",
                                       cycles, o1_last, o1_data, q1[0][8], q1[0][7:0]);
                end
            end
            if (ordy && q0.size() != 0) void'(q0.pop_front());
            if (ordy && q1.size() != 0) void'(q1.pop_front());
            if (pend && rdy0) begin
                for (int k = 0; k < 4; k++) begin
                    q0.push_back({(k == 3) & pl, pd[8*k +: 8]});
                    q1.push_back({(k == 3) & pl, pd[8*(3-k) +: 8]});
                end
                accepted++;
                pend = 1'b0;
            end
            cycles++;
        end
        checks++;
        if (cycles >= 20000) begin
            errors++; $display("FAIL rand_timeout: got %0d beats accepted expected 1000 within budget", accepted);
        end
        flush();
    endtask

    task automatic test_reset_midpacket();
        logic [31:0] beat = 32'h44332211;
        drive(1'b1, 1'b1, 32'h88776655, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_flushed cyc %0d: got %b/%b expected 0/0", i, o0_valid, o1_valid);
            end
        end
        drive(1'b1, 1'b1, beat, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (o0_valid !== 1'b1 || o0_data !== beat[8*k +: 8] || o1_data !== beat[8*(3-k) +: 8]) begin
                errors++; $display("FAIL midreset_new chunk %0d: got v=%b %h/%h expected v=1 %h/%h",
                                   k, o0_valid, o0_data, o1_data, beat[8*k +: 8], beat[8*(3-k) +: 8]);
            end
            checks++;
            if (o0_last !== 1'b0 || o1_last !== 1'b0) begin
                errors++; $display("FAIL midreset_last chunk %0d: got %b/%b expected 0/0", k, o0_last, o1_last);
            end
        end
        flush();
    endtask

    initial begin
        sresetn = 1'b0;
        in0.tvalid = 1'b0; in0.tdata = '0; in0.tlast = 1'b0;
        in1.tvalid = 1'b0; in1.tdata = '0; in1.tlast = 1'b0;
        out0.tready = 1'b0; out1.tready = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_random();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
- Converts a wide AXI-Stream into a narrower one by splitting each input beat into RATIO = AXIS_I_BYTES/AXIS_O_BYTES output beats.
- Sits directly downstream of the single-beat AXIS pipeline register, e.g. a 4-byte datapath feeding a byte-wide UART or SPI serialiser.
- Registered output with full throughput. A new wide beat is accepted in the same cycle the last chunk of the previous beat is consumed.

Parameters:
- AXIS_I_BYTES, 4, input tdata width in bytes.
- AXIS_O_BYTES, 1, output tdata width in bytes. AXIS_I_BYTES must be an integer multiple of it, otherwise elaboration fails.
- MSB_FIRST, 0, chunk order. 0 sends the least-significant chunk first; 1 sends the most-significant chunk first.

Ports:
- clk  input  1  clock.
- sresetn  input  1  synchronous active-low reset.
- axis_i_tready  output  1  input ready.
- axis_i_tvalid  input  1  input valid.
- axis_i_tlast  input  1  input end-of-packet.
- axis_i_tdata  input  AXIS_I_BYTES*8  input data.
- axis_o_tready  input  1  output ready.
- axis_o_tvalid  output  1  output valid.
- axis_o_tlast  output  1  output end-of-packet.
- axis_o_tdata  output  AXIS_O_BYTES*8  output data (current chunk).

Behaviour:
- Reset: clock clk; reset sresetn, synchronous, active-low.
  - During reset: axis_o_tvalid=0, chunk index=0, held-beat-valid=0, axis_o_tlast=0.
  - Data registers are don't-care.
  - Reset mid-packet discards the held beat and any unsent chunks. The first accepted beat after reset starts at chunk 0.
- State:
  - Holding register for one input beat (data and tlast), plus held-valid flag.
  - Chunk index idx, range 0..RATIO-1, width clog2(RATIO), minimum 1 bit.
- Input handshake:
  - axis_i_tready = !held_valid || (axis_o_tready && idx==RATIO-1), i.e. empty, or the last chunk is leaving this cycle.
  - axis_i_tready is a function of registered state and axis_o_tready only. It never depends on axis_i_tvalid.
- On input handshake:
  - Latch tdata/tlast, set held_valid=1, idx=0.
  - axis_o_tvalid rises the next cycle (latency 1 cycle).
- Output:
  - axis_o_tvalid = held_valid.
  - axis_o_tdata = chunk idx of the held beat. For MSB_FIRST=0, chunk k is bits [k*W +: W] with W=AXIS_O_BYTES*8. For MSB_FIRST=1, chunk k is chunk RATIO-1-k.
  - axis_o_tlast = held_tlast && idx==RATIO-1. It is never asserted on non-final chunks.
- On output handshake (tvalid && tready):
  - If idx<RATIO-1: idx increments.
  - If idx==RATIO-1 and input handshake in the same cycle: load the new beat, idx=0, held_valid stays 1 (no bubble).
  - If idx==RATIO-1 and no input handshake: held_valid=0, idx=0.
- Stall: while axis_o_tvalid && !axis_o_tready, tdata, tlast and idx are held stable (AXIS rule). Input is not accepted unless empty.
- Throughput: with constant tready, one output beat per cycle indefinitely. Input is accepted once per RATIO cycles.
- RATIO=1: behaves as a one-deep register with the same ready equation. idx is permanently 0.
- No tkeep/tuser. Partial final beats are not supported; every input beat yields exactly RATIO output beats.

Test Plan:
- Reset with axis_i_tvalid=1 and tready=1 held high → axis_o_tvalid=0 and axis_i_tready irrelevant during reset. After release, the first output appears 1 cycle after the first input handshake.
- AXIS_I_BYTES=4, MSB_FIRST=0, single beat 0xDDCCBBAA with tlast=1, tready=1 → outputs AA,BB,CC,DD on 4 consecutive cycles; tlast only with DD; axis_i_tready=0 during BB,CC and high in the DD cycle.
- Same beat with MSB_FIRST=1 → DD,CC,BB,AA; tlast with AA.
- Back-to-back beats 0x03020100 (tlast=0) and 0x07060504 (tlast=1), tvalid continuous, tready=1 → 00..07 on 8 consecutive cycles with no bubble; tlast only on 07.
- Random tready (50%) over 1000 random beats and packet lengths → scoreboard byte order and tlast positions match. Data is stable across every stall; no chunk is lost or duplicated.
- Assert sresetn=0 after 2 of 4 chunks are sent → after reset no remaining chunks are emitted. A new beat 0x44332211 yields 11,22,33,44.
